// File: rtl/rca_sum_accumulator_if.sv
// Valid/ready stream bundle used for the adder input and the total output.
// Ports: valid, ready, data[W-1:0]; master drives valid/data, slave drives ready.
interface rca_sum_accumulator_if #(
  parameter int W = 33
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/rca_sum_accumulator.sv
// Sums a programmed number of 33-bit adder results into a wide accumulator.
// Ports: clk, rst (sync, active-high), start, num_terms, sum (slave stream,
//   33-bit {cout,sum}), acc (master stream, ACC_W total), count_out,
//   overflow (sticky per run), busy. Option: RCA_ACC_SATURATE_EN.
module rca_sum_accumulator #(
  parameter int ACC_W   = 40,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_terms,
  rca_sum_accumulator_if.slave  sum,
  rca_sum_accumulator_if.master acc,
  output logic [COUNT_W-1:0] count_out,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   acc_nxt;
  logic             xfer;

  assign acc.data = acc_q;
  assign xfer     = sum.valid & sum.ready;
  assign acc_nxt  = {1'b0, acc_q}
                  + {{(ACC_W-32){1'b0}}, sum.data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_q     <= '0;
      count_out <= '0;
      overflow  <= 1'b0;
      sum.ready <= 1'b0;
      acc.valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc_q    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (num_terms != '0) begin
              state     <= ACCUM;
              count_out <= num_terms;
              sum.ready <= 1'b1;
            end else begin
              state     <= DONE;
              count_out <= '0;
              acc.valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
`ifdef RCA_ACC_SATURATE_EN
            // once saturated, hold all-ones for the rest of the run
            if (overflow | acc_nxt[ACC_W])
              acc_q <= '1;
            else
              acc_q <= acc_nxt[ACC_W-1:0];
`else
            acc_q <= acc_nxt[ACC_W-1:0];
`endif
            if (acc_nxt[ACC_W])
              overflow <= 1'b1;
            count_out <= count_out - 1'b1;
            if (count_out == COUNT_W'(1)) begin
              state     <= DONE;
              sum.ready <= 1'b0;
              acc.valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc.ready) begin
            state     <= IDLE;
            acc.valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          sum.ready <= 1'b0;
          acc.valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Directed bench for rca_sum_accumulator: a 40-bit instance for the main
// flows and a 33-bit instance for the overflow boundary.
module tb_rca_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic [7:0]  num_a = '0;
  logic [7:0]  cnt_a;
  logic        ovf_a;
  logic        busy_a;
  logic        start_b = 1'b0;
  logic [7:0]  num_b = '0;
  logic [7:0]  cnt_b;
  logic        ovf_b;
  logic        busy_b;
  int          nchk = 0;
  int          nerr = 0;

  rca_sum_accumulator_if #(.W(33)) sa ();
  rca_sum_accumulator_if #(.W(40)) aa ();
  rca_sum_accumulator_if #(.W(33)) sb ();
  rca_sum_accumulator_if #(.W(33)) ab ();

  rca_sum_accumulator #(.ACC_W(40), .COUNT_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .num_terms (num_a),
    .sum       (sa),
    .acc       (aa),
    .count_out (cnt_a),
    .overflow  (ovf_a),
    .busy      (busy_a)
  );

  rca_sum_accumulator #(.ACC_W(33), .COUNT_W(8)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .num_terms (num_b),
    .sum       (sb),
    .acc       (ab),
    .count_out (cnt_b),
    .overflow  (ovf_b),
    .busy      (busy_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_acc"}, 64'(aa.data), 64'h0);
    chk({tag, "_cnt"}, 64'(cnt_a), 64'h0);
    chk({tag, "_ovf"}, 64'(ovf_a), 64'h0);
    chk({tag, "_rdy"}, 64'(sa.ready), 64'h0);
    chk({tag, "_vld"}, 64'(aa.valid), 64'h0);
    chk({tag, "_busy"}, 64'(busy_a), 64'h0);
  endtask

  initial begin
    sa.valid = 1'b0;
    sa.data  = '0;
    aa.ready = 1'b0;
    sb.valid = 1'b0;
    sb.data  = '0;
    ab.ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_idle_a("rst");
    chk("rst_b_vld", 64'(ab.valid), 64'h0);

    // 1: reset mid-ACCUM
    start_a = 1'b1; num_a = 8'd3;
    step();
    start_a = 1'b0;
    chk("t1_rdy", 64'(sa.ready), 64'h1);
    chk("t1_cnt", 64'(cnt_a), 64'h3);
    sa.valid = 1'b1; sa.data = 33'h5;
    step();
    chk("t1_cnt2", 64'(cnt_a), 64'h2);
    sa.valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_idle_a("t1");

    // 2: three-term sum
    start_a = 1'b1; num_a = 8'd3;
    step();
    start_a = 1'b0;
    chk("t2_busy", 64'(busy_a), 64'h1);
    chk("t2_acc0", 64'(aa.data), 64'h0);
    sa.valid = 1'b1; sa.data = 33'h0_0000_0005;
    step();
    chk("t2_acc1", 64'(aa.data), 64'h5);
    sa.data = 33'h1_0000_0000;
    step();
    chk("t2_acc2", 64'(aa.data), 64'h1_0000_0005);
    chk("t2_vld0", 64'(aa.valid), 64'h0);
    sa.data = 33'h0_FFFF_FFFF;
    step();
    sa.valid = 1'b0;
    chk("t2_acc3", 64'(aa.data), 64'h02_0000_0004);
    chk("t2_vld", 64'(aa.valid), 64'h1);
    chk("t2_cnt", 64'(cnt_a), 64'h0);
    chk("t2_ovf", 64'(ovf_a), 64'h0);
    chk("t2_rdy", 64'(sa.ready), 64'h0);
    aa.ready = 1'b1;
    step();
    aa.ready = 1'b0;
    chk("t2_ack_vld", 64'(aa.valid), 64'h0);
    chk("t2_ack_busy", 64'(busy_a), 64'h0);
    chk("t2_held", 64'(aa.data), 64'h02_0000_0004);

    // 3: zero terms
    start_a = 1'b1; num_a = 8'd0;
    step();
    start_a = 1'b0;
    chk("t3_vld", 64'(aa.valid), 64'h1);
    chk("t3_acc", 64'(aa.data), 64'h0);
    chk("t3_rdy", 64'(sa.ready), 64'h0);
    aa.ready = 1'b1;
    step();
    chk("t3_ack", 64'(aa.valid), 64'h0);

    // 4: gaps in sum_valid
    start_a = 1'b1; num_a = 8'd2;
    step();
    start_a = 1'b0;
    chk("t4_cnt2", 64'(cnt_a), 64'h2);
    sa.valid = 1'b1; sa.data = 33'h7;
    step();
    chk("t4_cnt1", 64'(cnt_a), 64'h1);
    sa.valid = 1'b0;
    step();
    step();
    chk("t4_hold", 64'(cnt_a), 64'h1);
    chk("t4_hacc", 64'(aa.data), 64'h7);
    sa.valid = 1'b1; sa.data = 33'h9;
    step();
    sa.valid = 1'b0;
    chk("t4_cnt0", 64'(cnt_a), 64'h0);
    chk("t4_acc", 64'(aa.data), 64'h10);
    chk("t4_vld", 64'(aa.valid), 64'h1);
    step();
    chk("t4_ack", 64'(aa.valid), 64'h0);
    aa.ready = 1'b0;

    // 6: DONE held under back-pressure, start ignored
    start_a = 1'b1; num_a = 8'd1;
    step();
    start_a = 1'b0;
    sa.valid = 1'b1; sa.data = 33'h3;
    step();
    sa.valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t6_vld", 64'(aa.valid), 64'h1);
      chk("t6_acc", 64'(aa.data), 64'h3);
      step();
    end
    start_a = 1'b1; num_a = 8'd5;
    step();
    chk("t6_s_vld", 64'(aa.valid), 64'h1);
    chk("t6_s_acc", 64'(aa.data), 64'h3);
    chk("t6_s_cnt", 64'(cnt_a), 64'h0);
    chk("t6_s_rdy", 64'(sa.ready), 64'h0);
    aa.ready = 1'b1;
    step();
    start_a = 1'b0;
    aa.ready = 1'b0;
    chk("t6_idle_vld", 64'(aa.valid), 64'h0);
    chk("t6_idle_rdy", 64'(sa.ready), 64'h0);
    chk("t6_idle_busy", 64'(busy_a), 64'h0);
    chk("t6_idle_acc", 64'(aa.data), 64'h3);

    // 5: overflow at ACC_W=33
    start_b = 1'b1; num_b = 8'd2;
    step();
    start_b = 1'b0;
    sb.valid = 1'b1; sb.data = 33'h1_FFFF_FFFF;
    step();
    chk("t5_acc1", 64'(ab.data), 64'h1_FFFF_FFFF);
    chk("t5_ovf1", 64'(ovf_b), 64'h0);
    step();
    sb.valid = 1'b0;
    chk("t5_ovf", 64'(ovf_b), 64'h1);
`ifdef RCA_ACC_SATURATE_EN
    chk("t5_acc", 64'(ab.data), 64'h1_FFFF_FFFF);
`else
    chk("t5_acc", 64'(ab.data), 64'h1_FFFF_FFFE);
`endif
    chk("t5_vld", 64'(ab.valid), 64'h1);
    ab.ready = 1'b1;
    step();
    chk("t5_ovf_idle", 64'(ovf_b), 64'h1);
    start_b = 1'b1; num_b = 8'd1;
    step();
    start_b = 1'b0;
    chk("t5_ovf_clr", 64'(ovf_b), 64'h0);
    sb.valid = 1'b1; sb.data = 33'h1;
    step();
    sb.valid = 1'b0;
    chk("t5_new_acc", 64'(ab.data), 64'h1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
